// File: rtl/out_port_uart_tx.sv
// Watches the processor's 32-bit out_Port, queues every new value in a small FIFO
// and sends each queued word as four UART 8N1 bytes, least-significant byte first.
module out_port_uart_tx #(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   port_data,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic [1:0]                    dbg_state
);

  localparam int BW = $clog2(CLK_DIV);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          r_state;
  logic [BW-1:0]   r_baud;
  logic [2:0]      r_bit;
  logic [1:0]      r_byte;
  logic [31:0]     r_shift;
  logic            r_tx;

  logic [31:0]     r_last;
  logic [31:0]     r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_overflow;

  state_t          w_state_next;
  logic [BW-1:0]   w_baud_next;
  logic [2:0]      w_bit_next;
  logic [1:0]      w_byte_next;
  logic [31:0]     w_shift_next;
  logic            w_tx_next;
  logic            w_pop;
  logic            w_bit_end;
  logic [2:0]      w_bit_inc;
  logic [7:0]      w_shift_byte;
  logic            w_change;
  logic            w_full;
  logic            w_push;

  assign w_bit_end    = (r_baud == BAUD_LAST);
  assign w_bit_inc    = r_bit + 3'd1;
  assign w_shift_byte = r_shift[7:0];

  // A pop on the same edge frees a slot, so a change arriving while full is still accepted.
  assign w_change = (port_data != r_last);
  assign w_full   = (r_count == COUNT_FULL);
  assign w_push   = w_change && (!w_full || w_pop);

  always_comb begin
    w_state_next = r_state;
    w_baud_next  = r_baud;
    w_bit_next   = r_bit;
    w_byte_next  = r_byte;
    w_shift_next = r_shift;
    w_tx_next    = r_tx;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tx_next = 1'b1;
        if (r_count != '0) begin
          w_pop        = 1'b1;
          w_shift_next = r_mem[r_rd_ptr];
          w_byte_next  = 2'd0;
          w_baud_next  = '0;
          w_tx_next    = 1'b0;
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_baud_next  = '0;
          w_bit_next   = 3'd0;
          w_tx_next    = w_shift_byte[0];
          w_state_next = S_DATA;
        end else begin
          w_baud_next = r_baud + BW'(1);
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_baud_next = '0;
          if (r_bit == 3'd7) begin
            w_tx_next    = 1'b1;
            w_state_next = S_STOP;
          end else begin
            w_bit_next = w_bit_inc;
            w_tx_next  = w_shift_byte[w_bit_inc];
          end
        end else begin
          w_baud_next = r_baud + BW'(1);
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_baud_next = '0;
          if (r_byte == 2'd3) begin
            w_tx_next    = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_byte_next  = r_byte + 2'd1;
            w_shift_next = {8'h00, r_shift[31:8]};
            w_tx_next    = 1'b0;
            w_state_next = S_START;
          end
        end else begin
          w_baud_next = r_baud + BW'(1);
        end
      end
      default: begin
        w_tx_next    = 1'b1;
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= 3'd0;
      r_byte  <= 2'd0;
      r_shift <= 32'd0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_baud  <= w_baud_next;
      r_bit   <= w_bit_next;
      r_byte  <= w_byte_next;
      r_shift <= w_shift_next;
      r_tx    <= w_tx_next;
    end
  end

  // The shadow follows the port even when the word is dropped, so a held value is sent at most once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last     <= 32'd0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_last <= port_data;
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_change && !w_push) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= port_data;
  end

  assign tx         = r_tx;
  assign busy       = (r_state != S_IDLE);
  assign fifo_count = r_count;
  assign overflow   = r_overflow;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_out_port_uart_tx.sv
// Bench for out_port_uart_tx: a word-level model predicts queue occupancy, overflow and busy,
// and a serial-line monitor decodes frames and checks them against the expected word queue.
module tb_out_port_uart_tx;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int WORD_CYC   = 40 * CLK_DIV;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] port_data = 32'd0;
  logic        tx;
  logic        busy;
  logic [2:0]  fifo_count;
  logic        overflow;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  out_port_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .port_data  (port_data),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .dbg_state  (dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_words = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Word level: a change is queued if there is room after this edge's pop; a popped word
  // keeps the transmitter busy for WORD_CYC cycles, and the next pop needs one idle cycle.
  logic [31:0] m_last = 32'd0;
  logic [31:0] m_q[$];
  int          m_busy_cnt = 0;
  bit          m_ovf = 1'b0;
  logic [31:0] exp_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_last = 32'd0;
      m_q.delete();
      m_busy_cnt = 0;
      m_ovf = 1'b0;
      exp_q.delete();
    end else begin
      bit pop;
      pop = (m_busy_cnt == 0) && (m_q.size() != 0);
      if (pop) begin
        void'(m_q.pop_front());
        m_busy_cnt = WORD_CYC;
      end else if (m_busy_cnt > 0) begin
        m_busy_cnt--;
      end
      if (port_data != m_last) begin
        if (m_q.size() < FIFO_DEPTH) begin
          m_q.push_back(port_data);
          exp_q.push_back(port_data);
        end else begin
          m_ovf = 1'b1;
        end
        m_last = port_data;
      end
    end
  end

  // ---------------- per-cycle status checker ----------------
  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", 32'(busy), 32'(m_busy_cnt != 0));
      chk("fifo_count", 32'(fifo_count), 32'(m_q.size()));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (m_busy_cnt == 0) chk("tx_idle_high", 32'(tx), 32'd1);
    end
  end

  // ---------------- serial monitor / scoreboard ----------------
  bit          mon_active = 1'b0;
  int          mon_cnt = 0;
  logic [31:0] mon_word = 32'd0;

  always @(negedge clk) begin
    if (rst) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (tx == 1'b0) begin
        mon_active = 1'b1;
        mon_cnt = 0;
        mon_word = 32'd0;
      end
    end else begin
      int b;
      int p;
      mon_cnt++;
      b = mon_cnt / 40;
      p = mon_cnt % 40;
      if (p == 2) begin
        chk("start_bit", 32'(tx), 32'd0);
      end else if (p >= 6 && p <= 34 && ((p - 6) % 4) == 0) begin
        mon_word[8 * b + (p - 6) / 4] = tx;
      end else if (p == 38) begin
        chk("stop_bit", 32'(tx), 32'd1);
        if (b == 3) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_word: got %h expected none", mon_word);
          end else begin
            chk("word", mon_word, exp_q.pop_front());
          end
          n_words++;
          mon_active = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    port_data = 32'd0;
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((m_q.size() != 0 || m_busy_cnt != 0 || mon_active) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk(name, 32'(k < 3000), 32'd1);
    cyc(4);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w0;
    int n;
    int k;
    logic [31:0] pool[4];
    pool[0] = 32'h0000_0000;
    pool[1] = 32'h0000_0001;
    pool[2] = 32'hA5A5_A5A5;
    pool[3] = 32'hFFFF_FFFF;

    repeat (3) @(negedge clk);
    #2 rst = 1'b0;

    // Idle with the port at its reset value.
    cyc(500);
    chk("t1_tx", 32'(tx), 32'd1);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_count", 32'(fifo_count), 32'd0);
    chk("t1_words", 32'(n_words), 32'd0);

    // Single word: latency and frame length.
    w0 = n_words;
    @(negedge clk) port_data = 32'h0000_0003;
    @(negedge clk);
    chk("t2_tx_after_push", 32'(tx), 32'd1);
    chk("t2_count_after_push", 32'(fifo_count), 32'd1);
    @(negedge clk);
    chk("t2_tx_falls", 32'(tx), 32'd0);
    n = 1;
    k = 0;
    while (busy && k < 400) begin
      @(negedge clk);
      k++;
      if (busy) n++;
    end
    chk("t2_frame_len", 32'(n), 32'(WORD_CYC));
    drain("t2_drain");
    chk("t2_words", 32'(n_words - w0), 32'd1);

    // Six values on consecutive cycles: one popped, four queued, one dropped.
    do_reset();
    w0 = n_words;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk) port_data = 32'(i * 32'h1111_1111);
    end
    @(negedge clk);
    chk("t3_count_full", 32'(fifo_count), 32'd4);
    chk("t3_overflow", 32'(overflow), 32'd1);
    drain("t3_drain");
    chk("t3_words", 32'(n_words - w0), 32'd5);
    chk("t3_overflow_sticky", 32'(overflow), 32'd1);

    // Hold, change, return.
    do_reset();
    w0 = n_words;
    @(negedge clk) port_data = 32'hA5A5_A5A5;
    cyc(200);
    port_data = 32'h1234_5678;
    cyc(3);
    port_data = 32'hA5A5_A5A5;
    drain("t4_drain");
    chk("t4_words", 32'(n_words - w0), 32'd3);

    // Reset mid-frame with two words queued.
    do_reset();
    w0 = n_words;
    @(negedge clk) port_data = 32'hDEAD_0001;
    @(negedge clk) port_data = 32'hDEAD_0002;
    @(negedge clk) port_data = 32'hDEAD_0003;
    cyc(20);
    chk("t5_busy_before", 32'(busy), 32'd1);
    chk("t5_count_before", 32'(fifo_count), 32'd2);
    #2 rst = 1'b1;
    port_data = 32'd0;
    #1;
    chk("t5_tx_async", 32'(tx), 32'd1);
    chk("t5_count_async", 32'(fifo_count), 32'd0);
    chk("t5_busy_async", 32'(busy), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    cyc(300);
    chk("t5_no_resume", 32'(n_words - w0), 32'd0);
    chk("t5_tx_idle", 32'(tx), 32'd1);

    // New value on the very edge that pops a full FIFO.
    do_reset();
    w0 = n_words;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk) port_data = 32'h5000_0000 + 32'(i);
    end
    @(negedge clk);
    chk("t6_count_full", 32'(fifo_count), 32'd4);
    k = 0;
    while (m_busy_cnt != 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("t6_wait_idle", 32'(k < 400), 32'd1);
    port_data = 32'h5000_0006;
    @(negedge clk);
    chk("t6_count_stays", 32'(fifo_count), 32'd4);
    chk("t6_no_overflow", 32'(overflow), 32'd0);
    drain("t6_drain");
    chk("t6_words", 32'(n_words - w0), 32'd6);

    // Randomised traffic.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) begin
        if ($urandom_range(0, 1) == 0) port_data = pool[$urandom_range(0, 3)];
        else port_data = $urandom;
      end else if ($urandom_range(0, 299) == 0) begin
        for (int j = 0; j < 6; j++) begin
          port_data = $urandom;
          @(negedge clk);
        end
      end
    end
    drain("rand_drain");
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
